// File: rtl/plm_pkg.sv
// Shared constants, sample-word field layout and FSM state type for the
// pseudo-linear MNIST training scheduler.
package plm_pkg;

  localparam int N_PIX   = 784;
  localparam int N_CLS   = 10;
  localparam int WORD_W  = N_PIX + N_CLS;

  // Sample word: pixels in the upper field, one-hot label in the lower field
  localparam int LBL_LSB = 0;
  localparam int LBL_MSB = LBL_LSB + N_CLS - 1;
  localparam int PIX_LSB = N_CLS;
  localparam int PIX_MSB = WORD_W - 1;

  // Taps 16,15,13,4 map to bits 15,14,12,3
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hD008;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_APPLY,
    ST_DONE
  } state_t;

endpackage

// File: rtl/plm_lfsr16.sv
// 16-bit maximal-length Fibonacci LFSR; loads the seed on reset and steps
// once per cycle while en is high.
module plm_lfsr16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [15:0] value
);
  import plm_pkg::*;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  value <= LFSR_SEED;
    else if (en) value <= {value[14:0], ^(value & LFSR_TAPS)};
  end

endmodule

// File: rtl/plm_train_scheduler.sv
// Fetches labelled samples, broadcasts them to the class units, pulses
// parameter updates in train mode and scores matches in eval mode.
// Optional per-epoch address shuffling is enabled with PLM_SHUFFLE_EN.
module plm_train_scheduler #(
  parameter int ADDR_W  = 16,
  parameter int EPOCH_W = 8,
  parameter int RD_LAT  = 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic                               mode,
  input  logic [ADDR_W-1:0]                  cfg_num_samples,
  input  logic [EPOCH_W-1:0]                 cfg_num_epochs,
  input  logic [3:0]                         cfg_threshold,
  input  logic                               abort,
  output logic                               mem_rd_en,
  output logic [ADDR_W-1:0]                  mem_addr,
  input  logic [plm_pkg::WORD_W-1:0]         mem_rdata,
  output logic [plm_pkg::WORD_W-1:0]         image_data,
  output logic [plm_pkg::N_CLS-1:0]          upd_en,
  input  logic [plm_pkg::N_CLS-1:0]          class_result,
  output logic [3:0]                         threshold,
  output logic                               busy,
  output logic                               done,
  output logic [EPOCH_W-1:0]                 epoch_cnt,
  output logic [ADDR_W:0]                    correct_cnt
);
  import plm_pkg::*;

  localparam int WAIT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  state_t              state;
  logic                mode_q;
  logic [ADDR_W-1:0]   n_samp_q;
  logic [EPOCH_W-1:0]  n_ep_q;
  logic [ADDR_W-1:0]   idx;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                upd_q;

  logic [ADDR_W:0]     idx_inc;
  logic                last_sample;
  logic                last_epoch;
  logic                label_match;
  logic [ADDR_W-1:0]   nxt_idx;
  logic [ADDR_W-1:0]   fetch_idx;
  logic [ADDR_W-1:0]   fetch_addr;

  assign idx_inc     = {1'b0, idx} + (ADDR_W+1)'(1);
  assign last_sample = idx_inc >= {1'b0, n_samp_q};
  assign last_epoch  = ({1'b0, epoch_cnt} + (EPOCH_W+1)'(1)) == {1'b0, n_ep_q};
  assign label_match = class_result == image_data[LBL_MSB:LBL_LSB];
  assign nxt_idx     = last_sample ? '0 : idx_inc[ADDR_W-1:0];
  // Index of the sample the next FETCH will read (a new run always begins at 0)
  assign fetch_idx   = (state == ST_IDLE) ? '0 : nxt_idx;

  // Abort must kill an in-flight update in the very cycle it arrives
  assign upd_en = {N_CLS{upd_q & ~abort}};

`ifdef PLM_SHUFFLE_EN
  logic [15:0]       lfsr_val;
  logic [ADDR_W-1:0] off_q;
  logic [ADDR_W-1:0] off_next;
  logic [ADDR_W-1:0] nsamp_sel;
  logic              eval_sel;
  logic              lfsr_en;

  // Remainder of v / n by restoring shift-subtract, one step per lfsr bit
  function automatic logic [ADDR_W-1:0] lfsr_mod(input logic [15:0] v,
                                                 input logic [ADDR_W-1:0] n);
    logic [ADDR_W:0] r;
    r = '0;
    for (int i = 15; i >= 0; i--) begin
      r = {r[ADDR_W-1:0], v[i]};
      if (r >= {1'b0, n}) r = r - {1'b0, n};
    end
    return r[ADDR_W-1:0];
  endfunction

  function automatic logic [ADDR_W-1:0] wrap_add(input logic [ADDR_W-1:0] a,
                                                 input logic [ADDR_W-1:0] b,
                                                 input logic [ADDR_W-1:0] n);
    logic [ADDR_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, n}) s = s - {1'b0, n};
    return s[ADDR_W-1:0];
  endfunction

  assign nsamp_sel  = (state == ST_IDLE) ? cfg_num_samples : n_samp_q;
  assign eval_sel   = (state == ST_IDLE) ? mode : mode_q;
  assign off_next   = (fetch_idx != '0) ? off_q :
                      (eval_sel ? '0 : lfsr_mod(lfsr_val, nsamp_sel));
  assign fetch_addr = wrap_add(fetch_idx, off_next, nsamp_sel);
  // Step after the offset of the current epoch has been consumed
  assign lfsr_en    = (state == ST_FETCH) && (idx == '0) && !mode_q && !abort;

  plm_lfsr16 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (lfsr_en),
    .value (lfsr_val)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) off_q <= '0;
    else if ((state == ST_IDLE && start) || (state == ST_APPLY && !abort))
      off_q <= off_next;
  end
`else
  assign fetch_addr = fetch_idx;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      mode_q      <= 1'b0;
      n_samp_q    <= '0;
      n_ep_q      <= '0;
      threshold   <= '0;
      idx         <= '0;
      wait_cnt    <= '0;
      epoch_cnt   <= '0;
      correct_cnt <= '0;
      mem_rd_en   <= 1'b0;
      mem_addr    <= '0;
      image_data  <= '0;
      upd_q       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      mem_rd_en <= 1'b0;
      upd_q     <= 1'b0;
      done      <= 1'b0;
      if (abort && state != ST_IDLE) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              mode_q      <= mode;
              n_samp_q    <= cfg_num_samples;
              n_ep_q      <= cfg_num_epochs;
              threshold   <= cfg_threshold;
              epoch_cnt   <= '0;
              correct_cnt <= '0;
              idx         <= '0;
              busy        <= 1'b1;
              if (cfg_num_samples == '0 || (!mode && cfg_num_epochs == '0)) begin
                state <= ST_DONE;
                done  <= 1'b1;
              end else begin
                state     <= ST_FETCH;
                mem_rd_en <= 1'b1;
                mem_addr  <= fetch_addr;
              end
            end
          end
          ST_FETCH: begin
            state    <= ST_WAIT;
            wait_cnt <= '0;
          end
          ST_WAIT: begin
            if (wait_cnt == WAIT_W'(RD_LAT - 1)) begin
              state      <= ST_APPLY;
              image_data <= mem_rdata;
              upd_q      <= !mode_q;
            end else begin
              wait_cnt <= wait_cnt + WAIT_W'(1);
            end
          end
          ST_APPLY: begin
            if (mode_q && label_match) correct_cnt <= correct_cnt + (ADDR_W+1)'(1);
            idx <= nxt_idx;
            if (last_sample) epoch_cnt <= epoch_cnt + EPOCH_W'(1);
            if (last_sample && (mode_q || last_epoch)) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state     <= ST_FETCH;
              mem_rd_en <= 1'b1;
              mem_addr  <= fetch_addr;
            end
          end
          ST_DONE: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
